servo_frame_scheduler: RTL and testbench

Time-multiplexed pulse scheduler that drives up to N_CH hobby servos from one shared pulse timer, each servo getting its own slot inside a fixed 20 ms frame. It sits between the cube-solver move sequencer, which issues position commands over a valid/ready handshake, and the servo output pins. It replaces one free-running PWM divider per servo. Position updates are double-buffered and take effect only at frame boundaries, so no servo ever sees a truncated or stretched pulse.

---
 rtl/servo_frame_scheduler_if.sv | 10 +
 rtl/servo_frame_scheduler.sv | 136 +++++++++++++
 tb/tb_servo_frame_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_frame_scheduler_if.sv
// Position-command handshake between the move sequencer and the servo frame scheduler.
interface servo_frame_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic [11:0] cmd_us;

    modport master (output cmd_valid, output cmd_ch, output cmd_us, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_ch, input cmd_us, output cmd_ready);
endinterface

// File: rtl/servo_frame_scheduler.sv
// Time-multiplexed servo pulse scheduler: one shared µs timer, one slot per channel inside
// a fixed frame, double-buffered positions that switch over only at frame boundaries.
module servo_frame_scheduler #(
    parameter int unsigned US_DIV    = 50,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned SLOT_US   = 2500,
    parameter int unsigned FRAME_US  = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned CENTER_US = 1500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    servo_frame_scheduler_if.slave cmd,
    output logic [N_CH-1:0]        pwm_out,
    output logic                   frame_start,
    output logic                   busy
);

    localparam int unsigned TAIL_US = FRAME_US - N_CH * SLOT_US;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, TAIL} state_t;

    state_t      state, state_nx;
    logic [2:0]  ch, ch_nx;
    logic [15:0] presc;
    logic [14:0] tick_us, tick_inc;
    logic        us_wrap, restart, start_frame, rdy_q;
    logic [11:0] shadow [N_CH];
    logic [11:0] active [N_CH];
    logic [11:0] cur_active, cmd_clamped;

    assign us_wrap       = (presc == 16'(US_DIV - 1));
    assign tick_inc      = tick_us + 15'd1;
    assign cmd.cmd_ready = rdy_q & ~frame_start;

    always_comb begin
        cmd_clamped = cmd.cmd_us;
        if (cmd.cmd_us < 12'(MIN_US))
            cmd_clamped = 12'(MIN_US);
        else if (cmd.cmd_us > 12'(MAX_US))
            cmd_clamped = 12'(MAX_US);
    end

    // In the copy cycle active[] is stale; shadow[] is frozen (cmd_ready=0) and is what lands.
    always_comb begin
        cur_active = '0;
        for (int unsigned c = 0; c < N_CH; c++)
            if (ch == 3'(c))
                cur_active = frame_start ? shadow[c] : active[c];
    end

    always_comb begin
        state_nx    = state;
        ch_nx       = ch;
        start_frame = 1'b0;
        restart     = 1'b0;
        case (state)
            IDLE: if (enable) start_frame = 1'b1;
            HIGH: begin
                if (us_wrap && tick_inc == 15'(cur_active))
                    state_nx = enable ? LOW : IDLE;
            end
            LOW: begin
                if (!enable)
                    state_nx = IDLE;
                else if (us_wrap && tick_inc == 15'(SLOT_US)) begin
                    restart = 1'b1;
                    if (ch != 3'(N_CH - 1)) begin
                        ch_nx    = ch + 3'd1;
                        state_nx = HIGH;
                    end else if (TAIL_US == 0)
                        start_frame = 1'b1;
                    else
                        state_nx = TAIL;
                end
            end
            TAIL: begin
                if (!enable)
                    state_nx = IDLE;
                else if (us_wrap && tick_inc == 15'(TAIL_US))
                    start_frame = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (start_frame) begin
            state_nx = HIGH;
            ch_nx    = '0;
            restart  = 1'b1;
        end
        if (state_nx == IDLE)
            restart = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ch          <= '0;
            presc       <= '0;
            tick_us     <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            rdy_q       <= 1'b0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                shadow[c] <= 12'(CENTER_US);
                active[c] <= 12'(CENTER_US);
            end
        end else begin
            state       <= state_nx;
            ch          <= ch_nx;
            frame_start <= start_frame;
            busy        <= (state != IDLE);
            rdy_q       <= 1'b1;
            if (restart) begin
                presc   <= '0;
                tick_us <= '0;
            end else if (us_wrap) begin
                presc   <= '0;
                tick_us <= tick_inc;
            end else begin
                presc   <= presc + 16'd1;
            end
            // pwm_out trails the state by one cycle so every pulse is exactly the HIGH dwell time.
            for (int unsigned c = 0; c < N_CH; c++) begin
                pwm_out[c] <= (state == HIGH) && (ch == 3'(c));
                if (frame_start)
                    active[c] <= shadow[c];
                if (cmd.cmd_valid && cmd.cmd_ready && cmd.cmd_ch == 3'(c))
                    shadow[c] <= cmd_clamped;
            end
        end
    end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler, run with a scaled-down timebase (2 clk per µs tick).
module tb_servo_frame_scheduler;
    localparam int unsigned US_DIV    = 2;
    localparam int unsigned N_CH      = 4;
    localparam int unsigned SLOT_US   = 25;
    localparam int unsigned FRAME_US  = 120;
    localparam int unsigned MIN_US    = 10;
    localparam int unsigned MAX_US    = 20;
    localparam int unsigned CENTER_US = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] pwm_out;
    logic       frame_start, busy;

    servo_frame_scheduler_if ifc();

    servo_frame_scheduler #(
        .US_DIV(US_DIV), .N_CH(N_CH), .SLOT_US(SLOT_US), .FRAME_US(FRAME_US),
        .MIN_US(MIN_US), .MAX_US(MAX_US), .CENTER_US(CENTER_US)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cmd(ifc),
        .pwm_out(pwm_out), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0, nfs = 0, fs_last = 0, fs_prev = 0, onehot_err = 0;
    int rise [4] = '{default: 0};
    int width [4] = '{default: 0};
    int npulse [4] = '{default: 0};
    logic [3:0] prev = '0;
    int n_checks = 0, n_fail = 0;

    // Edge/width monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        int now;
        now = cyc + 1;
        cyc <= now;
        for (int c = 0; c < 4; c++) begin
            if (pwm_out[c] && !prev[c]) rise[c] <= now;
            if (!pwm_out[c] && prev[c]) begin
                width[c]  <= now - rise[c];
                npulse[c] <= npulse[c] + 1;
            end
        end
        prev <= pwm_out;
        if (frame_start) begin
            fs_prev <= fs_last;
            fs_last <= now;
            nfs     <= nfs + 1;
        end
        if ($countones(pwm_out) > 1) onehot_err <= onehot_err + 1;
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] us;
        int          exp_w;
    } vec_t;
    vec_t vecs [10];
    int   mdl [4];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    task automatic send(input logic [2:0] c, input logic [11:0] u);
        logic r;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_ch    = c;
        ifc.cmd_us    = u;
        for (int i = 0; i < 8; i++) begin
            r = ifc.cmd_ready;
            tick();
            if (r) begin
                ifc.cmd_valid = 1'b0;
                return;
            end
        end
        ifc.cmd_valid = 1'b0;
        timeout("cmd_accept");
    endtask

    task automatic wait_fs();
        int target;
        target = nfs + 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (nfs >= target) return;
        end
        timeout("frame_start_wait");
    endtask

    task automatic wait_pulse(input int c, output int w);
        int target;
        target = npulse[c] + 1;
        w = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (npulse[c] >= target) begin
                w = width[c];
                return;
            end
        end
        timeout("pulse_end_wait");
    endtask

    task automatic wait_rise(input int c);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pwm_out[c]) return;
        end
        timeout("pulse_rise_wait");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, w, sum0, sum1;
        vecs[0] = '{3'd0, 12'd3,    20};
        vecs[1] = '{3'd0, 12'd3000, 40};
        vecs[2] = '{3'd1, 12'd20,   40};
        vecs[3] = '{3'd3, 12'd10,   20};
        vecs[4] = '{3'd2, 12'd0,    20};
        vecs[5] = '{3'd1, 12'd4095, 40};
        vecs[6] = '{3'd3, 12'd17,   34};
        vecs[7] = '{3'd2, 12'd9,    20};
        vecs[8] = '{3'd0, 12'd21,   40};
        vecs[9] = '{3'd0, 12'd13,   26};
        mdl = '{15, 15, 15, 15};

        ifc.cmd_valid = 1'b0;
        ifc.cmd_ch    = '0;
        ifc.cmd_us    = '0;

        // reset state
        tick();
        tick();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ifc.cmd_ready), 0);
        reset = 1'b1;
        #1;
        check("ready_before_first_clk", int'(ifc.cmd_ready), 0);
        tick();
        check("ready_after_first_clk", int'(ifc.cmd_ready), 1);
        check("idle_busy", int'(busy), 0);

        // default frame timing
        n0 = cyc;
        enable = 1'b1;
        wait_fs();
        check("frame_start_latency", fs_last - n0, 1);
        wait_pulse(3, w);
        check("pwm0_latency", rise[0] - n0, 2);
        for (int c = 0; c < 4; c++) check($sformatf("center_width_ch%0d", c), width[c], 30);
        check("slot_offset_ch1", rise[1] - rise[0], 50);
        check("slot_offset_ch3", rise[3] - rise[0], 150);
        wait_fs();
        check("frame_period", fs_last - fs_prev, 240);

        // mid-frame write takes effect next frame only
        send(3'd2, 12'd12);
        wait_pulse(2, w);
        check("ch2_current_frame", w, 30);
        wait_pulse(2, w);
        check("ch2_next_frame", w, 24);
        mdl[2] = 12;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].ch, vecs[i].us);
            wait_fs();
            wait_pulse(int'(vecs[i].ch), w);
            check($sformatf("vec%0d_ch%0d_width", i, vecs[i].ch), w, vecs[i].exp_w);
            mdl[vecs[i].ch] = vecs[i].exp_w / 2;
        end

        // out-of-range channel is discarded
        send(3'd5, 12'd11);
        wait_fs();
        wait_pulse(3, w);
        for (int c = 0; c < 4; c++) check($sformatf("discard_ch%0d", c), width[c], mdl[c] * 2);

        // command held across the frame-start (copy) cycle
        wait_fs();
        check("ready_low_in_copy_cycle", int'(ifc.cmd_ready), 0);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_ch    = 3'd1;
        ifc.cmd_us    = 12'd18;
        tick();
        check("ready_back_after_copy", int'(ifc.cmd_ready), 1);
        tick();
        ifc.cmd_valid = 1'b0;
        wait_pulse(1, w);
        check("stalled_cmd_not_this_frame", w, mdl[1] * 2);
        wait_pulse(1, w);
        check("stalled_cmd_next_frame", w, 36);
        mdl[1] = 18;

        // enable dropped during ch1 pulse
        wait_rise(1);
        repeat (5) tick();
        enable = 1'b0;
        wait_pulse(1, w);
        check("ch1_full_width_on_disable", w, 36);
        check("busy_low_after_disable", int'(busy), 0);
        sum0 = npulse[0] + npulse[1] + npulse[2] + npulse[3];
        repeat (300) tick();
        sum1 = npulse[0] + npulse[1] + npulse[2] + npulse[3];
        check("no_pulses_when_disabled", sum1 - sum0, 0);
        check("busy_stays_low", int'(busy), 0);

        // asynchronous reset in the middle of a ch3 pulse
        send(3'd3, 12'd20);
        enable = 1'b1;
        wait_fs();
        wait_rise(3);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("pwm_async_clear", int'(pwm_out), 0);
        check("busy_async_clear", int'(busy), 0);
        tick();
        tick();
        reset = 1'b1;
        wait_pulse(3, w);
        check("ch3_center_after_reset", w, 30);

        check("onehot_violations", onehot_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
